// File: rtl/i2s_tx.sv
// Philips I2S transmitter: accepts 24-bit stereo frames over valid/ready into a one-frame
// shadow buffer and serializes them MSB-first with the one-bit delay after each lrclk edge.
module i2s_tx #(
    parameter int unsigned width_p    = 24,
    parameter int unsigned slot_p     = 32,
    parameter int unsigned sclk_div_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] l_data_i,
    input  logic [width_p-1:0] r_data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               sclk_o,
    output logic               lrclk_o,
    output logic               sdata_o,
    output logic               underrun_o
);

    if (slot_p < width_p + 1) begin : g_bad_slot
        $error("i2s_tx: slot_p must be at least width_p+1");
    end
    if (sclk_div_p < 1) begin : g_bad_div
        $error("i2s_tx: sclk_div_p must be at least 1");
    end

    localparam int unsigned DivW = (sclk_div_p > 1) ? $clog2(sclk_div_p) : 1;
    localparam int unsigned BitW = $clog2(2 * slot_p);
    localparam int unsigned IdxW = (width_p > 1) ? $clog2(width_p) : 1;

    localparam logic [DivW-1:0] DivLast  = DivW'(sclk_div_p - 1);
    localparam logic [BitW-1:0] BitLast  = BitW'(2 * slot_p - 1);
    localparam logic [BitW-1:0] SlotLen  = BitW'(slot_p);
    localparam logic [BitW-1:0] WidthPos = BitW'(width_p);

    logic [DivW-1:0]    div_cnt_q, div_cnt_d;
    logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
    logic               sclk_q, sclk_d;
    logic               lrclk_q, lrclk_d;
    logic               sdata_q, sdata_d;
    logic               underrun_q, underrun_d;
    logic               ready_q, ready_d;
    logic               shadow_full_q, shadow_full_d;
    logic [width_p-1:0] l_shadow_q, l_shadow_d;
    logic [width_p-1:0] r_shadow_q, r_shadow_d;
    logic [width_p-1:0] l_shift_q, l_shift_d;
    logic [width_p-1:0] r_shift_q, r_shift_d;

    logic               tc;
    logic               fall_evt;
    logic               frame_start;
    logic               capture;
    logic [BitW-1:0]    bit_next;
    logic [BitW-1:0]    slot_pos;
    logic               in_right;
    logic [width_p-1:0] cur_word;
    logic [IdxW-1:0]    bit_idx;
    logic               bit_out;

    always_comb begin
        tc          = (div_cnt_q == DivLast);
        fall_evt    = tc & sclk_q;
        bit_next    = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + 1'b1;
        frame_start = fall_evt & (bit_cnt_q == BitLast);
        capture     = valid_i & ready_q;

        div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
        sclk_d    = tc ? ~sclk_q : sclk_q;
        bit_cnt_d = fall_evt ? bit_next : bit_cnt_q;

        // Frame registers are reloaded at frame start; an empty shadow sends silence.
        l_shift_d = l_shift_q;
        r_shift_d = r_shift_q;
        if (frame_start) begin
            l_shift_d = shadow_full_q ? l_shadow_q : '0;
            r_shift_d = shadow_full_q ? r_shadow_q : '0;
        end

        in_right = (bit_next >= SlotLen);
        slot_pos = in_right ? bit_next - SlotLen : bit_next;
        cur_word = in_right ? r_shift_d : l_shift_d;
        bit_idx  = IdxW'(width_p - int'(slot_pos));
        bit_out  = 1'b0;
        if (slot_pos >= BitW'(1) && slot_pos <= WidthPos) begin
            bit_out = cur_word[bit_idx];
        end

        lrclk_d    = fall_evt ? in_right : lrclk_q;
        sdata_d    = fall_evt ? bit_out : sdata_q;
        underrun_d = frame_start & ~shadow_full_q;

        // capture and frame_start-with-full are exclusive since capture needs an empty shadow.
        shadow_full_d = shadow_full_q;
        if (frame_start && shadow_full_q) begin
            shadow_full_d = 1'b0;
        end else if (capture) begin
            shadow_full_d = 1'b1;
        end
        l_shadow_d = capture ? l_data_i : l_shadow_q;
        r_shadow_d = capture ? r_data_i : r_shadow_q;
        ready_d    = ~shadow_full_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_cnt_q     <= '0;
            bit_cnt_q     <= BitLast;
            sclk_q        <= 1'b0;
            lrclk_q       <= 1'b1;
            sdata_q       <= 1'b0;
            underrun_q    <= 1'b0;
            ready_q       <= 1'b0;
            shadow_full_q <= 1'b0;
            l_shadow_q    <= '0;
            r_shadow_q    <= '0;
            l_shift_q     <= '0;
            r_shift_q     <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            sclk_q        <= sclk_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            underrun_q    <= underrun_d;
            ready_q       <= ready_d;
            shadow_full_q <= shadow_full_d;
            l_shadow_q    <= l_shadow_d;
            r_shadow_q    <= r_shadow_d;
            l_shift_q     <= l_shift_d;
            r_shift_q     <= r_shift_d;
        end
    end

    assign ready_o    = ready_q;
    assign sclk_o     = sclk_q;
    assign lrclk_o    = lrclk_q;
    assign sdata_o    = sdata_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: captures whole frames off the wire on sclk rises and compares
// them against frames built from the handed-over samples.
module tb_i2s_tx;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [23:0] l_data_i = '0;
    logic [23:0] r_data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o, sclk_o, lrclk_o, sdata_o, underrun_o;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int base = 0;
    logic hs_last = 1'b0;
    logic auto_mode = 1'b0;
    logic [23:0] auto_n = '0;
    int hs_n = 0;
    int hs_t [8];

    i2s_tx dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .l_data_i  (l_data_i),
        .r_data_i  (r_data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .sclk_o    (sclk_o),
        .lrclk_o   (lrclk_o),
        .sdata_o   (sdata_o),
        .underrun_o(underrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: note whether a handshake happens at this edge, then settle 1 ns after it.
    task automatic tick();
        hs_last = valid_i & ready_o;
        @(posedge clk_i);
        #1;
        cyc++;
        if (auto_mode && hs_last) begin
            if (hs_n < 8) hs_t[hs_n] = cyc;
            hs_n++;
            auto_n   = auto_n + 24'd1;
            l_data_i = auto_n;
            r_data_i = ~auto_n;
        end
    endtask

    task automatic do_reset(input int n);
        reset_i = 1'b1;
        valid_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
        reset_i = 1'b0;
        base = cyc;
    endtask

    task automatic send(input logic [23:0] l, input logic [23:0] r);
        logic done;
        done = 1'b0;
        l_data_i = l;
        r_data_i = r;
        valid_i = 1'b1;
        for (int i = 0; i < 600 && !done; i++) begin
            tick();
            if (hs_last) done = 1'b1;
        end
        valid_i = 1'b0;
        check("send_handshake", 64'(done), 64'd1);
    endtask

    function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] e;
        e = '0;
        for (int k = 1; k <= 24; k++) begin
            e[k]      = l[24-k];
            e[32 + k] = r[24-k];
        end
        return e;
    endfunction

    // Waits for lrclk falling (frame start), then records sdata/lrclk on the next 64 sclk rises.
    task automatic get_frame(output logic [63:0] d, output logic [63:0] lr, output int ur_n,
                             output logic ur0, output int t0);
        logic prev_lr, prev_sclk, found;
        int n;
        d = '0; lr = '0; ur_n = 0; ur0 = 1'b0; t0 = 0; found = 1'b0;
        prev_lr = lrclk_o;
        for (int i = 0; i < 600 && !found; i++) begin
            tick();
            if (prev_lr && !lrclk_o) begin
                found = 1'b1;
                ur0 = underrun_o;
                ur_n = underrun_o ? 1 : 0;
                t0 = cyc;
            end
            prev_lr = lrclk_o;
        end
        if (!found) begin
            check("frame_start_timeout", 64'd0, 64'd1);
        end else begin
            n = 0;
            prev_sclk = sclk_o;
            for (int i = 0; i < 400 && n < 64; i++) begin
                tick();
                if (underrun_o) ur_n++;
                if (!prev_sclk && sclk_o) begin
                    d[n] = sdata_o;
                    lr[n] = lrclk_o;
                    n++;
                end
                prev_sclk = sclk_o;
            end
            check("frame_bits_timeout", 64'(n), 64'd64);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sclk"}, 64'(sclk_o), 64'd0);
        check({tag, "_lrclk"}, 64'(lrclk_o), 64'd1);
        check({tag, "_sdata"}, 64'(sdata_o), 64'd0);
        check({tag, "_ready"}, 64'(ready_o), 64'd0);
        check({tag, "_underrun"}, 64'(underrun_o), 64'd0);
    endtask

    localparam logic [63:0] LrExp = 64'hFFFF_FFFF_0000_0000;

    initial begin
        logic [63:0] d, lr;
        int ur_n, t0, t_prev, garbage_hs;
        logic ur0;

        // 1: reset values and ready after release
        do_reset(5);
        check_reset_vals("rst");
        tick();
        check("ready_after_release", 64'(ready_o), 64'd1);
        check("underrun_after_release", 64'(underrun_o), 64'd0);

        // 2: first frame carries the pre-loaded samples
        send(24'hA5A5A5, 24'h5A5A5A);
        get_frame(d, lr, ur_n, ur0, t0);
        check("f0_data", d, exp_frame(24'hA5A5A5, 24'h5A5A5A));
        check("f0_lrclk", lr, LrExp);
        check("f0_underrun", 64'(ur_n), 64'd0);
        check("f0_start_time", 64'(t0 - base), 64'd4);
        t_prev = t0;

        // 3: no data -> silent frames, single underrun pulse each 256 cycles
        for (int f = 0; f < 2; f++) begin
            get_frame(d, lr, ur_n, ur0, t0);
            check("silent_data", d, 64'd0);
            check("silent_ur_at_lr_fall", 64'(ur0), 64'd1);
            check("silent_ur_count", 64'(ur_n), 64'd1);
            check("frame_period", 64'(t0 - t_prev), 64'd256);
            t_prev = t0;
        end

        // 4: valid held high with L=n, R=~n
        do_reset(2);
        auto_n = '0;
        l_data_i = 24'd0;
        r_data_i = 24'hFFFFFF;
        hs_n = 0;
        auto_mode = 1'b1;
        valid_i = 1'b1;
        for (int f = 0; f < 3; f++) begin
            get_frame(d, lr, ur_n, ur0, t0);
            check("stream_data", d, exp_frame(24'(f), ~24'(f)));
            check("stream_underrun", 64'(ur_n), 64'd0);
        end
        auto_mode = 1'b0;
        valid_i = 1'b0;
        check("stream_hs_count", 64'(hs_n), 64'd4);
        check("stream_hs0", 64'(hs_t[0] - base), 64'd2);
        check("stream_hs1", 64'(hs_t[1] - base), 64'd5);
        check("stream_hs2", 64'(hs_t[2] - base), 64'd261);
        check("stream_hs3", 64'(hs_t[3] - base), 64'd517);

        // 5: data churning while ready is low must not be captured
        do_reset(2);
        send(24'h111111, 24'h222222);
        send(24'h123456, 24'hFEDCBA);
        garbage_hs = 0;
        for (int i = 0; i < 150; i++) begin
            l_data_i = 24'($urandom);
            r_data_i = 24'($urandom);
            valid_i = 1'b1;
            tick();
            if (hs_last) garbage_hs++;
        end
        valid_i = 1'b0;
        check("hold_no_capture", 64'(garbage_hs), 64'd0);
        get_frame(d, lr, ur_n, ur0, t0);
        check("hold_data", d, exp_frame(24'h123456, 24'hFEDCBA));
        check("hold_underrun", 64'(ur_n), 64'd0);

        // 6: reset mid-frame with a full shadow discards it
        do_reset(2);
        send(24'h0F0F0F, 24'hF0F0F0);
        send(24'hC3C3C3, 24'h3C3C3C);
        while (cyc - base < 166) tick();
        check("mid_shadow_full", 64'(ready_o), 64'd0);
        reset_i = 1'b1;
        tick();
        check_reset_vals("midrst");
        reset_i = 1'b0;
        base = cyc;
        for (int f = 0; f < 2; f++) begin
            get_frame(d, lr, ur_n, ur0, t0);
            check("post_rst_silent", d, 64'd0);
            check("post_rst_ur", 64'(ur0), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
